// File: rtl/mips_muldiv_pkg.sv
// Shared encodings, widths and helpers for the iterative HI/LO multiply/divide sequencer.
package mips_muldiv_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STEPS  = DATA_W;
  localparam int unsigned CNT_W  = $clog2(STEPS);
  localparam int unsigned ACC_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIX   = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// 64-bit accumulator datapath: shift-add multiply, restoring divide and final sign fixup.
module muldiv_iter_core
  import mips_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              fix_i,
  input  logic              is_div_i,
  input  logic              is_signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output hilo_t             res_o
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  hilo_t             res_q, res_d;
  logic [DATA_W-1:0] opb_q, dividend_q;
  logic              is_div_q, neg_res_q, neg_rem_q, dz_q;

  logic [DATA_W-1:0] mag_a, mag_b, acc_hi, acc_lo;
  logic [DATA_W:0]   mul_sum, rem_shift, trial;

  assign mag_a  = magnitude(a_i, is_signed_i);
  assign mag_b  = magnitude(b_i, is_signed_i);
  assign acc_hi = acc_q[ACC_W-1:DATA_W];
  assign acc_lo = acc_q[DATA_W-1:0];

  // Multiply adds into the upper half; divide shifts the remainder:dividend pair left.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : (DATA_W+1)'(0));
  assign rem_shift = acc_q[ACC_W-1:DATA_W-1];
  assign trial     = rem_shift - {1'b0, opb_q};

  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    if (load_i) begin
      acc_d = {DATA_W'(0), is_div_i ? mag_a : mag_b};
    end else if (step_i) begin
      if (!is_div_q)
        acc_d = {mul_sum, acc_lo[DATA_W-1:1]};
      else if (trial[DATA_W])
        acc_d = {rem_shift[DATA_W-1:0], acc_lo[DATA_W-2:0], 1'b0};
      else
        acc_d = {trial[DATA_W-1:0], acc_lo[DATA_W-2:0], 1'b1};
    end
    if (fix_i) begin
      if (!is_div_q) begin
        res_d = neg_res_q ? hilo_t'(ACC_W'(-acc_q)) : hilo_t'(acc_q);
      end else if (dz_q) begin
        res_d.hi = dividend_q;
        res_d.lo = '1;
      end else begin
        res_d.hi = neg_rem_q ? DATA_W'(-acc_hi) : acc_hi;
        res_d.lo = neg_res_q ? DATA_W'(-acc_lo) : acc_lo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      res_q      <= '0;
      opb_q      <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
      if (load_i) begin
        opb_q      <= is_div_i ? mag_b : mag_a;
        dividend_q <= a_i;
        is_div_q   <= is_div_i;
        neg_res_q  <= is_signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
        neg_rem_q  <= is_signed_i & a_i[DATA_W-1];
        dz_q       <= (b_i == '0);
      end
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/mult_div_sequencer.sv
// HI/LO write-side controller: sequences 32-step mult/div, stalls HI/LO users, muxes MTHI/MTLO.
module mult_div_sequencer
  import mips_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_value,
  input  logic [DATA_W-1:0] rt_value,
  input  logic              mt_hi,
  input  logic              mt_lo,
  input  logic [DATA_W-1:0] mt_data,
  input  logic              mf_req,
  output logic              busy,
  output logic              stall,
  output logic              hi_enable,
  output logic              lo_enable,
  output logic [DATA_W-1:0] hi_pw,
  output logic [DATA_W-1:0] lo_pw
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load, step, fix;
  hilo_t            res;

  muldiv_iter_core u_core (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_i      (step),
    .fix_i       (fix),
    .is_div_i    (op_is_div(op_e'(op))),
    .is_signed_i (op_is_signed(op_e'(op))),
    .a_i         (rs_value),
    .b_i         (rt_value),
    .res_o       (res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    hi_enable = 1'b0;
    lo_enable = 1'b0;
    hi_pw     = '0;
    lo_pw     = '0;
    busy      = (state_q != ST_IDLE);
    stall     = busy & (start | mf_req | mt_hi | mt_lo);
    unique case (state_q)
      ST_IDLE: begin
        // MT writes pass straight through; a coincident start is still accepted.
        hi_enable = mt_hi;
        lo_enable = mt_lo;
        hi_pw     = mt_hi ? mt_data : '0;
        lo_pw     = mt_lo ? mt_data : '0;
        if (start) begin
          load    = 1'b1;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step    = 1'b1;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(STEPS - 1))
          state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        hi_enable = 1'b1;
        lo_enable = 1'b1;
        hi_pw     = res.hi;
        lo_pw     = res.lo;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: arithmetic reference model plus HI/LO timing checks.
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_value, rt_value, mt_data;
  logic        mt_hi, mt_lo, mf_req;
  logic        busy, stall, hi_enable, lo_enable;
  logic [31:0] hi_pw, lo_pw;

  logic [31:0] hi_reg = '0, lo_reg = '0;
  logic [63:0] exp_q[$];
  int          vectors = 0;
  int          errors  = 0;

  mult_div_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_value  (rs_value),
    .rt_value  (rt_value),
    .mt_hi     (mt_hi),
    .mt_lo     (mt_lo),
    .mt_data   (mt_data),
    .mf_req    (mf_req),
    .busy      (busy),
    .stall     (stall),
    .hi_enable (hi_enable),
    .lo_enable (lo_enable),
    .hi_pw     (hi_pw),
    .lo_pw     (lo_pw)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // External HiRegister/LoRegister as the datapath would hold them.
  always @(posedge clk) begin
    if (hi_enable) hi_reg <= hi_pw;
    if (lo_enable) lo_reg <= lo_pw;
  end

  // Operation write-back: both enables while busy is only the WRITE cycle.
  always @(negedge clk) begin
    if (!reset && busy && hi_enable && lo_enable) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_hi", hi_pw, e[63:32]);
        check_eq("sb_lo", lo_pw, e[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    int n = 0;
    exp_q.push_back(ref_model(o, a, b));
    start = 1'b1; op = o; rs_value = a; rt_value = b;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    while (busy && n < 60) begin
      busy_cycles++;
      @(negedge clk);
      n++;
    end
    if (n >= 60) check_eq("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int          bc, cnt, bad, n;
    logic [31:0] saved_hi;
    reset = 1'b1; start = 1'b0; op = '0; rs_value = '0; rt_value = '0;
    mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0; mf_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_hi_en", 32'(hi_enable), 32'd0);
    check_eq("rst_lo_en", 32'(lo_enable), 32'd0);
    check_eq("rst_hi_pw", hi_pw, 32'd0);
    check_eq("rst_lo_pw", lo_pw, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases, issued back-to-back.
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, bc);
    check_eq("multu_busy_cycles", 32'(bc), 32'd34);
    check_eq("multu_hi_reg", hi_reg, 32'h0000_0001);
    check_eq("multu_lo_reg", lo_reg, 32'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, bc);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, bc);
    run_op(2'b11, 32'h0000_1234, 32'd0, bc);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, bc);
    check_eq("div0_signed_hi_reg", hi_reg, 32'hFFFF_FFF9);

    // Randomised operations, some with zero or tiny divisors.
    for (int i = 0; i < 12; i++) begin
      logic [31:0] b;
      b = (i % 4 == 3) ? 32'd0 : ((i % 2 == 1) ? $urandom : 32'($urandom_range(1, 20)));
      run_op(2'($urandom_range(0, 3)), $urandom, b, bc);
      check_eq("rand_busy_cycles", 32'(bc), 32'd34);
    end

    // MFHI/MFLO held from cycle 10 of a MULT until the result is written.
    exp_q.push_back(ref_model(2'b00, 32'd1000, 32'hFFFF_FF00));
    start = 1'b1; op = 2'b00; rs_value = 32'd1000; rt_value = 32'hFFFF_FF00;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    mf_req = 1'b1;
    cnt = 0; n = 0;
    do begin
      @(negedge clk);
      if (stall) cnt++;
      n++;
    end while (busy && n < 60);
    check_eq("mf_stall_cycles", 32'(cnt), 32'd24);
    check_eq("mf_released", 32'(stall), 32'd0);
    check_eq("mf_read_hi", hi_reg, 32'hFFFF_FFFF);
    check_eq("mf_read_lo", lo_reg, 32'hFFFC_1800);
    mf_req = 1'b0;
    @(negedge clk);

    // MTHI in IDLE writes through with no stall.
    mt_hi = 1'b1; mt_data = 32'h0000_CAFE;
    #1;
    check_eq("mthi_hi_en", 32'(hi_enable), 32'd1);
    check_eq("mthi_lo_en", 32'(lo_enable), 32'd0);
    check_eq("mthi_hi_pw", hi_pw, 32'h0000_CAFE);
    check_eq("mthi_stall", 32'(stall), 32'd0);
    @(negedge clk);
    mt_hi = 1'b0;
    check_eq("mthi_hi_reg", hi_reg, 32'h0000_CAFE);

    // MTLO during RUN stalls and is only written after the op completes.
    exp_q.push_back(ref_model(2'b01, 32'd7, 32'd9));
    start = 1'b1; op = 2'b01; rs_value = 32'd7; rt_value = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    mt_lo = 1'b1; mt_data = 32'h0000_0055;
    #1;
    check_eq("mtlo_run_stall", 32'(stall), 32'd1);
    bad = 0; n = 0;
    while (busy && n < 60) begin
      if (lo_enable && !hi_enable) bad++;
      @(negedge clk);
      n++;
    end
    check_eq("mtlo_no_early_write", 32'(bad), 32'd0);
    check_eq("mtlo_op_result_lo", lo_reg, 32'd63);
    #1;
    check_eq("mtlo_retry_en", 32'(lo_enable), 32'd1);
    check_eq("mtlo_retry_pw", lo_pw, 32'h0000_0055);
    check_eq("mtlo_retry_stall", 32'(stall), 32'd0);
    @(negedge clk);
    mt_lo = 1'b0;
    check_eq("mtlo_lo_reg", lo_reg, 32'h0000_0055);

    // Asynchronous reset in the middle of a DIVU abandons it without touching HI/LO.
    saved_hi = hi_reg;
    exp_q.push_back(ref_model(2'b11, 32'd100, 32'd7));
    start = 1'b1; op = 2'b11; rs_value = 32'd100; rt_value = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_hi_en", 32'(hi_enable), 32'd0);
    check_eq("rst_mid_lo_en", 32'(lo_enable), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mid_hi_kept", hi_reg, saved_hi);
    @(negedge clk);
    run_op(2'b11, 32'd100, 32'd7, bc);
    check_eq("post_rst_busy_cycles", 32'(bc), 32'd34);
    check_eq("post_rst_lo_reg", lo_reg, 32'd14);
    check_eq("post_rst_hi_reg", hi_reg, 32'd2);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

Iterative multiply/divide controller that owns the write side of the HI/LO register pair in the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU from the ID/EX stage and runs a 32-step shift-add or restoring-divide loop. It then pulses the HI and LO write enables with the results. While busy it holds the pipeline off any instruction that touches HI/LO, and it arbitrates MTHI/MTLO writes against its own.

## Interface
- DATA_W, 32, operand/result width
- STEPS, 32, iterations per operation (= DATA_W)
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  issue of a mult/div op (one-cycle pulse from EX)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- rs_value  in  32  multiplicand / dividend
- rt_value  in  32  multiplier / divisor
- mt_hi, mt_lo  in  1  MTHI / MTLO request from EX
- mt_data  in  32  data for MTHI/MTLO
- mf_req  in  1  MFHI or MFLO in EX
- busy  out  1  operation in flight
- stall  out  1  freeze IF/ID/EX
- hi_enable, lo_enable  out  1  write enables to HiRegister / LoRegister
- hi_pw, lo_pw  out  32  write data to HiRegister / LoRegister

## Operation
- FSM states: IDLE, RUN, FIX, WRITE. busy = (state != IDLE).
- IDLE: start=1 -> latch op, capture operand magnitudes (signed ops: absolute value) and sign flags, count=0, go to RUN.
- RUN: one step per cycle. MULT: conditional add of multiplicand, then 64-bit shift right. DIV: 64-bit remainder shift left, then trial subtract with restore. count increments; at count=STEPS-1 go to FIX.
- FIX: signed ops only. Product is negated (64-bit) if the signs differ. Quotient is negated if the signs differ. Remainder takes the dividend's sign. Results are registered. Go to WRITE.
- WRITE: hi_enable=lo_enable=1. Mult: hi_pw=product[63:32], lo_pw=product[31:0]. Div: hi_pw=remainder, lo_pw=quotient. Go to IDLE.
- Divide by zero (rt_value=0, either signedness): lo_pw=32'hFFFFFFFF, hi_pw=rs_value, no sign fixup.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Falls out of the magnitude datapath with no special case.
- MTHI/MTLO in IDLE: hi_enable/lo_enable asserted combinationally that cycle with hi_pw/lo_pw=mt_data. No stall.
- start together with mt_* in IDLE: the mt write is done this cycle and start is accepted. The op result overwrites at WRITE.
- stall = busy & (start | mf_req | mt_hi | mt_lo). A stalled request is held by the pipeline and retried.
- start while busy is not accepted; the in-flight op is unaffected.
- reset: state=IDLE, count=0, all result/operand registers 0, no HI/LO write.

## Timing
- Reset values: busy=0, stall=0, hi_enable=0, lo_enable=0, hi_pw=0, lo_pw=0.
- start sampled at edge E0. RUN covers E1..E32. FIX ends at E33. WRITE is the cycle after E33. HiRegister/LoRegister capture at E34.
- busy is high from after E0 through the WRITE cycle (34 cycles). Back-to-back start is accepted in the cycle after WRITE.
- An MFHI/MFLO stalled during WRITE is released after E34 and reads the new value.
- Enables are high for exactly one cycle per operation. hi_pw/lo_pw are stable whenever the enables are high.
- Reset mid-RUN: FSM is IDLE immediately (asynchronous). HI/LO keep their prior contents.

## Structure
- Shared package mips_muldiv_pkg: op encodings, FSM state encoding, DATA_W/STEPS constants.
- One sub-module, muldiv_iter_core: the 64-bit accumulator, shift/add/subtract step, and sign fixup. Controlled by step/load/fix strobes.
- The top level holds the FSM, counter, stall logic, and HI/LO write mux.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=2 -> at E34: hi=0x00000001, lo=0xFFFFFFFE. busy high for 34 cycles.
- MULT rs=-3, rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- mf_req at cycle 10 of a MULT -> stall=1 until after E34. Next read returns the product.
- MTHI 0xCAFE in IDLE -> hi_enable that cycle, hi_pw=0xCAFE, stall=0. MTLO during RUN -> stall=1, no lo_enable until WRITE.
- reset asserted at cycle 10 of DIVU -> busy=0 and enables=0 immediately. A new start after reset completes normally.
